// File: rtl/if_icache_assoc.sv
// Instruction-fetch stage with an N-way set-associative I-cache, round-robin
// replacement, a registered miss FSM toward the memory controller, and fence.i.
module if_icache_assoc #(
    parameter int              AW       = 32,
    parameter int              SETS     = 128,
    parameter int              WAYS     = 2,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          br_flag_i,
    input  logic [AW-1:0] br_tar_i,
    input  logic          stall_i,
    input  logic          fence_i,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic          mem_ok_i,
    input  logic [31:0]   mem_data_i,
    output logic [AW-1:0] pc_o,
    output logic [31:0]   inst_o,
    output logic          inst_valid_o,
    output logic          if_stall_o,
    output logic [31:0]   hit_cnt_o,
    output logic [31:0]   miss_cnt_o
);

    localparam int IW = $clog2(SETS);
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TW = AW - IW - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FILL_ONLY,
        S_DISCARD
    } state_t;

    state_t          state_q;
    logic            mem_req_q;
    logic [AW-1:0]   mem_addr_q;
    logic [31:0]     miss_cnt_q;
    logic [AW-1:0]   pc_q, pc_d;
    logic [31:0]     hit_cnt_q, hit_cnt_d;

    logic [WAYS-1:0] valid_q [SETS];
    logic [WW-1:0]   rr_q    [SETS];
    logic [TW-1:0]   tag_q   [SETS][WAYS];
    logic [31:0]     data_q  [SETS][WAYS];

    logic [IW-1:0]   idx;
    logic [TW-1:0]   tag;
    logic            hit;
    logic [31:0]     hit_data;
    logic            bypass;
    logic            inst_valid;

    logic [IW-1:0]   fill_idx;
    logic [TW-1:0]   fill_tag;
    logic            fill_we;
    logic [WW-1:0]   victim;
    logic            victim_found;
    logic [WW-1:0]   rr_next;

    assign idx      = pc_q[IW+1:2];
    assign tag      = pc_q[AW-1:IW+2];
    assign fill_idx = mem_addr_q[IW+1:2];
    assign fill_tag = mem_addr_q[AW-1:IW+2];

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit      = 1'b1;
                hit_data = data_q[idx][w];
            end
        end
    end

    // A redirect or fence in the response cycle makes the word stale for the pipeline.
    assign bypass = (state_q == S_FETCH) && mem_ok_i && (mem_addr_q == pc_q)
                    && !br_flag_i && !fence_i;

    assign inst_valid   = hit | bypass;
    assign inst_valid_o = inst_valid;
    assign if_stall_o   = ~inst_valid;
    assign inst_o       = hit ? hit_data : (bypass ? mem_data_i : 32'd0);

    assign fill_we = mem_ok_i && !fence_i &&
                     ((state_q == S_FETCH) || (state_q == S_FILL_ONLY));

    always_comb begin
        victim       = rr_q[fill_idx];
        victim_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!victim_found && !valid_q[fill_idx][w]) begin
                victim       = WW'(w);
                victim_found = 1'b1;
            end
        end
    end

    assign rr_next = (WAYS == 1) ? '0 : rr_q[fill_idx] + WW'(1);

    always_comb begin
        pc_d = pc_q;
        if (br_flag_i) begin
            pc_d = br_tar_i;
        end else if (inst_valid && !stall_i) begin
            pc_d = pc_q + AW'(4);
        end
    end

    assign hit_cnt_d = (hit && !stall_i && !br_flag_i) ? hit_cnt_q + 32'd1 : hit_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            hit_cnt_q <= '0;
        end else begin
            pc_q      <= pc_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    // Miss FSM: every outstanding request waits for its mem_ok_i before returning to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!hit && !br_flag_i && !fence_i) begin
                        mem_addr_q <= pc_q;
                        mem_req_q  <= 1'b1;
                        miss_cnt_q <= miss_cnt_q + 32'd1;
                        state_q    <= S_FETCH;
                    end
                end
                S_FETCH, S_FILL_ONLY, S_DISCARD: begin
                    if (mem_ok_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (fence_i) begin
                        state_q <= S_DISCARD;
                    end else if (br_flag_i && (state_q == S_FETCH)) begin
                        state_q <= S_FILL_ONLY;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (fence_i) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else if (fill_we) begin
            valid_q[fill_idx][victim] <= 1'b1;
            rr_q[fill_idx]            <= rr_next;
        end
    end

    // Tag and data storage carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx][victim]  <= fill_tag;
            data_q[fill_idx][victim] <= mem_data_i;
        end
    end

    assign pc_o       = pc_q;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;
    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_if_icache_assoc.sv
// Bench for if_icache_assoc: memory model with 3-cycle response, scoreboard of
// expected fetch results checked when the stage presents a valid instruction.
module tb_if_icache_assoc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        br_flag_i = 1'b0;
    logic [31:0] br_tar_i = '0;
    logic        stall_i = 1'b0;
    logic        fence_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ok_i = 1'b0;
    logic [31:0] mem_data_i = '0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        if_stall_o;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

    int checks = 0;
    int errors = 0;
    int exp_miss = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          hit;
    } exp_t;
    exp_t sb[$];

    if_icache_assoc #(.AW(32), .SETS(128), .WAYS(2), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .br_flag_i(br_flag_i), .br_tar_i(br_tar_i),
        .stall_i(stall_i), .fence_i(fence_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ok_i(mem_ok_i), .mem_data_i(mem_data_i),
        .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o),
        .if_stall_o(if_stall_o), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hC0DE_0000;
    endfunction

    // Memory controller: mem_ok_i three cycles after the request is seen; a reset aborts it.
    initial begin : mem_model
        logic [31:0] a;
        bit abort;
        forever begin
            @(negedge clk);
            if (rst && mem_req_o) begin
                a = mem_addr_o;
                abort = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    if (!rst) abort = 1'b1;
                end
                if (!abort) begin
                    mem_ok_i = 1'b1;
                    mem_data_i = memf(a);
                    @(negedge clk);
                    mem_ok_i = 1'b0;
                    mem_data_i = '0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] addr, input bit hit);
        exp_t e;
        e.addr = addr;
        e.data = memf(addr);
        e.hit = hit;
        sb.push_back(e);
        if (!hit) exp_miss++;
    endtask

    // Wait for a valid instruction, then pop the scoreboard and compare.
    task automatic expect_delivery(input string name);
        exp_t e;
        int n;
        bit saw;
        n = 0;
        saw = 1'b0;
        while (!inst_valid_o && n < 20) begin
            if (mem_req_o) saw = 1'b1;
            tick();
            n++;
        end
        if (mem_req_o) saw = 1'b1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            if ({inst_valid_o, pc_o, inst_o, saw} !== {1'b1, e.addr, e.data, ~e.hit}) begin
                errors++;
                $display("FAIL %s: valid=%b pc=%h inst=%h req_seen=%b, expected valid=1 pc=%h inst=%h req_seen=%b",
                         name, inst_valid_o, pc_o, inst_o, saw, e.addr, e.data, ~e.hit);
            end
        end
        checks++;
        if (miss_cnt_o !== exp_miss) begin
            errors++;
            $display("FAIL %s_miss_cnt: got %0d expected %0d", name, miss_cnt_o, exp_miss);
        end
    endtask

    task automatic fetch(input logic [31:0] addr, input bit hit, input string name);
        br_flag_i = 1'b1;
        br_tar_i = addr;
        push_exp(addr, hit);
        tick();
        br_flag_i = 1'b0;
        expect_delivery(name);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if ({pc_o, mem_req_o, mem_addr_o, hit_cnt_o, miss_cnt_o} !== {32'h0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: pc=%h req=%b addr=%h hits=%0d misses=%0d, expected all zero",
                     pc_o, mem_req_o, mem_addr_o, hit_cnt_o, miss_cnt_o);
        end
        checks++;
        if ({inst_valid_o, if_stall_o, inst_o} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b stall=%b inst=%h, expected 0 1 0",
                     inst_valid_o, if_stall_o, inst_o);
        end
        rst = 1'b1;
    endtask

    task automatic test_first_miss();
        exp_t e;
        int n;
        tick();
        checks++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h, expected 1 00000000", mem_req_o, mem_addr_o);
        end
        push_exp(32'h0, 1'b0);
        n = 0;
        while (!inst_valid_o && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL first_latency: bypass after %0d cycles, expected 3", n);
        end
        e = sb.pop_front();
        checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, e.addr, e.data}) begin
            errors++;
            $display("FAIL first_bypass: valid=%b pc=%h inst=%h, expected 1 %h %h",
                     inst_valid_o, pc_o, inst_o, e.addr, e.data);
        end
        tick();
        checks++;
        if ({pc_o, miss_cnt_o} !== {32'h4, 32'd1}) begin
            errors++;
            $display("FAIL first_advance: pc=%h misses=%0d, expected 00000004 1", pc_o, miss_cnt_o);
        end
    endtask

    task automatic test_loop_hits();
        exp_t e;
        int n;
        for (int a = 4; a <= 12; a += 4) push_exp(32'(a), 1'b0);
        n = 0;
        while (pc_o !== 32'h10 && n < 80) begin
            if (inst_valid_o) begin
                checks++;
                e = sb.pop_front();
                if ({pc_o, inst_o} !== {e.addr, e.data}) begin
                    errors++;
                    $display("FAIL loop_pass1: pc=%h inst=%h, expected %h %h", pc_o, inst_o, e.addr, e.data);
                end
            end
            tick();
            n++;
        end
        checks++;
        if (n >= 80 || sb.size() != 0 || miss_cnt_o !== exp_miss) begin
            errors++;
            $display("FAIL loop_pass1_done: cycles=%0d pending=%0d misses=%0d, expected <80 0 %0d",
                     n, sb.size(), miss_cnt_o, exp_miss);
        end
        br_flag_i = 1'b1;
        br_tar_i = 32'h0;
        tick();
        br_flag_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_exp(32'(4 * i), 1'b1);
            e = sb.pop_front();
            checks++;
            if ({inst_valid_o, mem_req_o, pc_o, inst_o} !== {1'b1, 1'b0, e.addr, e.data}) begin
                errors++;
                $display("FAIL loop_hit%0d: valid=%b req=%b pc=%h inst=%h, expected 1 0 %h %h",
                         i, inst_valid_o, mem_req_o, pc_o, inst_o, e.addr, e.data);
            end
            tick();
        end
        checks++;
        if ({pc_o, hit_cnt_o} !== {32'h10, 32'd4}) begin
            errors++;
            $display("FAIL loop_hit_cnt: pc=%h hits=%0d, expected 00000010 4", pc_o, hit_cnt_o);
        end
        stall_i = 1'b1;
    endtask

    task automatic test_eviction();
        fetch(32'h200, 1'b0, "evict_fill_200");
        fetch(32'h400, 1'b0, "evict_fill_400");
        fetch(32'h200, 1'b1, "evict_keep_200");
        fetch(32'h000, 1'b0, "evict_refetch_000");
    endtask

    task automatic test_redirect_fill();
        int n;
        bit stale;
        br_flag_i = 1'b1;
        br_tar_i = 32'h10;
        tick();
        br_flag_i = 1'b0;
        exp_miss++;
        tick();
        checks++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h10}) begin
            errors++;
            $display("FAIL redir_req: req=%b addr=%h, expected 1 00000010", mem_req_o, mem_addr_o);
        end
        br_flag_i = 1'b1;
        br_tar_i = 32'h80;
        push_exp(32'h80, 1'b0);
        tick();
        br_flag_i = 1'b0;
        checks++;
        if ({pc_o, inst_valid_o} !== {32'h80, 1'b0}) begin
            errors++;
            $display("FAIL redir_pc: pc=%h valid=%b, expected 00000080 0", pc_o, inst_valid_o);
        end
        stale = 1'b0;
        n = 0;
        while (!stale && n < 20) begin
            if (mem_ok_i) begin
                stale = 1'b1;
                checks++;
                if (inst_valid_o !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_no_bypass: valid=%b inst=%h, expected 0", inst_valid_o, inst_o);
                end
            end
            tick();
            n++;
        end
        expect_delivery("redir_target_80");
        tick();
        fetch(32'h10, 1'b1, "redir_line_10_kept");
    endtask

    task automatic test_fence_vs_fill();
        int n;
        br_flag_i = 1'b1;
        br_tar_i = 32'h300;
        tick();
        br_flag_i = 1'b0;
        exp_miss++;
        n = 0;
        while (!mem_ok_i && n < 20) begin
            tick();
            n++;
        end
        fence_i = 1'b1;
        #1;
        checks++;
        if ({mem_ok_i, inst_valid_o} !== {1'b1, 1'b0}) begin
            errors++;
            $display("FAIL fence_fill_bypass: ok=%b valid=%b, expected 1 0", mem_ok_i, inst_valid_o);
        end
        tick();
        fence_i = 1'b0;
        push_exp(32'h300, 1'b0);
        expect_delivery("fence_refetch_300");
        tick();
        fetch(32'h200, 1'b0, "fence_cleared_200");
    endtask

    task automatic test_reset_mid_fill();
        br_flag_i = 1'b1;
        br_tar_i = 32'h500;
        tick();
        br_flag_i = 1'b0;
        tick();
        checks++;
        if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h500}) begin
            errors++;
            $display("FAIL rstmid_req: req=%b addr=%h, expected 1 00000500", mem_req_o, mem_addr_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, mem_addr_o, pc_o, miss_cnt_o, hit_cnt_o} !== {1'b0, 32'h0, 32'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL rstmid_async: req=%b addr=%h pc=%h misses=%0d hits=%0d, expected all zero",
                     mem_req_o, mem_addr_o, pc_o, miss_cnt_o, hit_cnt_o);
        end
        tick();
        tick();
        rst = 1'b1;
        exp_miss = 0;
        push_exp(32'h0, 1'b0);
        expect_delivery("rstmid_refetch_0");
        tick();
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_loop_hits();
        test_eviction();
        test_redirect_fill();
        test_fence_vs_fill();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_icache_assoc.md
Name: if_icache_assoc

Overview:
- Parametrised successor to the direct-mapped instruction-fetch stage.
- Holds the PC and an N-way set-associative I-cache with explicit valid bits and per-set round-robin replacement.
- Runs a registered miss FSM against the memory controller; supports fence.i invalidation and hit/miss counters.
- Sits between the memory controller and the IF/ID pipeline register; drives the pipeline stall request.

Parameters:
AW, 32, instruction address width.
SETS, 128, number of sets; power of 2, at least 2.
WAYS, 2, associativity; legal values 1, 2, 4.
RESET_PC, 32'h0, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset; one clock; reset is asynchronous and active-low.
br_flag_i  in  1  branch/jump redirect request.
br_tar_i  in  AW  redirect target.
stall_i  in  1  downstream stall; PC must hold.
fence_i  in  1  single-cycle pulse; invalidate the entire cache.
mem_req_o  out  1  line-fill request, held until mem_ok_i.
mem_addr_o  out  AW  word address of the fill.
mem_ok_i  in  1  single-cycle pulse; fill data valid.
mem_data_i  in  32  fill instruction word.
pc_o  out  AW  current fetch PC.
inst_o  out  32  instruction at pc_o; 0 when not valid.
inst_valid_o  out  1  inst_o is valid this cycle.
if_stall_o  out  1  equals ~inst_valid_o.
hit_cnt_o  out  32  count of instructions delivered from cache hits.
miss_cnt_o  out  32  count of misses issued.

Behaviour:
- Address split:
  - Bits [1:0] are ignored.
  - idx = pc[log2(SETS)+1:2].
  - tag = pc[AW-1:log2(SETS)+2].
- Reset (rst=0, asynchronous):
  - pc_o=RESET_PC; all valid bits=0; all round-robin pointers=0.
  - FSM=IDLE; mem_req_o=0; mem_addr_o=0; both counters=0.
  - Tag and data arrays are not reset.
  - Reset asserted mid-fill aborts the fill. A mem_ok_i arriving after reset release while in IDLE is ignored.
- Lookup (combinational):
  - hit = any way in set idx with valid=1 and tag match.
  - On hit: inst_o = that way's data; inst_valid_o=1.
  - Bypass: in FETCH with mem_ok_i=1 and mem_addr_o==pc_o, inst_o=mem_data_i and inst_valid_o=1.
  - Otherwise inst_o=0 and inst_valid_o=0.
- PC update, in priority order:
  1. br_flag_i: pc_o<=br_tar_i. Applies even when stall_i=1.
  2. Else if inst_valid_o=1 and stall_i=0: pc_o<=pc_o+4. Wraps modulo 2^AW.
  3. Else hold.
- FSM states:
  - IDLE: if ~hit, ~br_flag_i and ~fence_i, then latch mem_addr_o<=pc_o, set mem_req_o<=1, increment miss_cnt_o, go to FETCH. A hit is visible with 0 cycles of latency; a miss raises mem_req_o 1 cycle later.
  - FETCH: hold mem_req_o/mem_addr_o.
    - br_flag_i → FILL_ONLY.
    - fence_i → DISCARD.
    - mem_ok_i → write the fill, clear mem_req_o, go to IDLE.
  - FILL_ONLY: the redirect has made the response stale for the pipeline, but the line is still good. No bypass. fence_i → DISCARD. mem_ok_i → write the fill, go to IDLE.
  - DISCARD: no bypass, no write. mem_ok_i → go to IDLE.
  - Simultaneous mem_ok_i and br_flag_i in FETCH: the fill is written, bypass is suppressed, PC redirects, go to IDLE.
  - Simultaneous mem_ok_i and fence_i: fence wins; no write; all valid bits cleared.
- Fill write:
  - Victim = lowest-numbered invalid way in the set; if none, the way given by rr[set].
  - Write tag, data and valid=1 to the victim.
  - rr[set] advances modulo WAYS on every fill into that set.
  - WAYS=1 always uses way 0.
- fence_i: clears all valid bits at the next edge, in any state. A hit in the same cycle is still delivered.
- Counters:
  - hit_cnt_o increments when the instruction comes from the cache array, inst_valid_o=1, stall_i=0 and br_flag_i=0.
  - miss_cnt_o increments on IDLE→FETCH.
  - Both wrap at 2^32.

Test Plan:
1. Reset with RESET_PC=0, empty cache, memory returns mem_ok_i 3 cycles after each request → mem_req_o rises at cycle 1 with mem_addr_o=0; bypass delivers at the mem_ok_i cycle; pc_o=4 next cycle; miss_cnt_o=1.
2. Loop over 0x0–0xC twice (WAYS=2, SETS=128) → second pass has 4 consecutive hit cycles with no mem_req_o; hit_cnt_o=4.
3. Fetch addresses 0x000, 0x200, 0x400, all in set 0 → the third fill evicts way 0; refetching 0x000 misses while 0x200 still hits.
4. br_flag_i to 0x80 while FETCH for 0x10 → pc_o=0x80; no bypass; 0x10 is written. A later fetch of 0x10 hits.
5. fence_i in the same cycle as mem_ok_i → the line is not written; a refetch of the same address issues a new mem_req_o; miss_cnt_o increments.
6. rst pulsed low while in FETCH → mem_req_o=0 asynchronously; pc_o=RESET_PC; all valid bits=0.
